// File: rtl/interp_nco_ctrl.sv
// Symbol-timing NCO controller for a Farrow-style interpolator: counts warm-up
// samples, then runs a modulo-1 down-counter whose underflows emit strobe and mu.
module interp_nco_ctrl #(
   parameter int               NCO_W    = 16,
   parameter int               MU_WIDTH = 10,
   parameter int               MU_FRAC  = 9,
   parameter logic [NCO_W-1:0] W_NOM    = 16'h8000,
   parameter logic [NCO_W-1:0] W_MIN    = 16'h6000,
   parameter logic [NCO_W-1:0] W_MAX    = 16'hA000,
   parameter int               WARMUP   = 4
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                in_valid,
   input  logic [15:0]         v_err,
   input  logic                v_valid,
   output logic [MU_WIDTH-1:0] mu,
   output logic                strobe,
   output logic                sym_phase,
   output logic                running,
   output logic                o_dbg_state
);

   // in_valid and v_valid are plain per-cycle qualifiers: the block has no
   // ready/backpressure, so every cycle with a qualifier high is consumed.

   localparam int SW = NCO_W + 2;
   localparam int CW = $clog2(WARMUP + 1);

   typedef enum logic {S_WARMUP = 1'b0, S_RUN = 1'b1} state_t;

   state_t                r_state;
   state_t                w_state_next;
   logic [CW-1:0]         r_warm_cnt;
   logic [NCO_W-1:0]      r_eta;
   logic [15:0]           r_v_hold;
   logic [MU_WIDTH-1:0]   r_mu;
   logic                  r_strobe;
   logic                  r_sym_phase;

   logic signed [SW-1:0]  w_step_raw;
   logic [NCO_W-1:0]      w_step;
   logic [NCO_W-1:0]      w_eta_next;
   logic                  w_underflow;
   logic [MU_WIDTH-1:0]   w_mu_next;
   logic                  w_last_warm;

   // Step computed wide enough that W_NOM + v_hold can never wrap before clamping.
   assign w_step_raw = $signed({2'b00, W_NOM})
                     + $signed({{(SW-16){r_v_hold[15]}}, r_v_hold});

   always_comb begin
      w_step = w_step_raw[NCO_W-1:0];
      if (w_step_raw < $signed({2'b00, W_MIN}))
         w_step = W_MIN;
      else if (w_step_raw > $signed({2'b00, W_MAX}))
         w_step = W_MAX;
   end

   assign w_underflow = {1'b0, r_eta} < {1'b0, w_step};
   assign w_eta_next  = r_eta - w_step;
   assign w_mu_next   = MU_WIDTH'(r_eta[NCO_W-1 -: MU_FRAC]);
   assign w_last_warm = (r_warm_cnt == CW'(WARMUP - 1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         r_state <= S_WARMUP;
      else
         r_state <= w_state_next;
   end

   always_comb begin
      w_state_next = r_state;
      if (r_state == S_WARMUP && in_valid && w_last_warm)
         w_state_next = S_RUN;
   end

   always_comb begin
      running     = (r_state == S_RUN);
      o_dbg_state = r_state;
   end

   // The sample that completes warm-up only fills the delay line; the NCO
   // starts on the following accepted sample.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_warm_cnt  <= '0;
         r_eta       <= '1;
         r_v_hold    <= '0;
         r_mu        <= '0;
         r_strobe    <= 1'b0;
         r_sym_phase <= 1'b0;
      end else begin
         r_strobe <= 1'b0;
         if (v_valid)
            r_v_hold <= v_err;
         if (r_state == S_WARMUP && in_valid)
            r_warm_cnt <= r_warm_cnt + CW'(1);
         if (r_state == S_RUN && in_valid) begin
            r_eta <= w_eta_next;
            if (w_underflow) begin
               r_strobe    <= 1'b1;
               r_mu        <= w_mu_next;
               r_sym_phase <= ~r_sym_phase;
            end
         end
      end
   end

   assign mu        = r_mu;
   assign strobe    = r_strobe;
   assign sym_phase = r_sym_phase;

endmodule

// File: tb/tb_interp_nco_ctrl.sv
// Self-checking bench for interp_nco_ctrl: directed vectors, an arithmetic
// model of the timing loop, and a per-cycle scoreboard compare.
module tb_interp_nco_ctrl;

   localparam int WARMUP = 4;
   localparam int W_NOM  = 32768;
   localparam int W_MIN  = 24576;
   localparam int W_MAX  = 40960;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid = 1'b0;
   logic        v_valid = 1'b0;
   logic [15:0] v_err = '0;
   logic [9:0]  mu;
   logic        strobe;
   logic        sym_phase;
   logic        running;
   logic        dbg_state;

   int checks = 0;
   int failures = 0;

   logic [12:0] exp_q[$];
   logic [12:0] cmp_exp;
   logic [12:0] cmp_act;

   int m_eta, m_vhold, m_cnt, m_mu, m_strb_cnt;
   bit m_run, m_strobe, m_phase;
   int d_strb_cnt = 0;

   always #5 clk = ~clk;

   interp_nco_ctrl dut (
      .clk         (clk),
      .rst         (rst),
      .in_valid    (in_valid),
      .v_err       (v_err),
      .v_valid     (v_valid),
      .mu          (mu),
      .strobe      (strobe),
      .sym_phase   (sym_phase),
      .running     (running),
      .o_dbg_state (dbg_state)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic model_reset();
      m_eta = 65535; m_vhold = 0; m_cnt = 0; m_mu = 0;
      m_run = 0; m_strobe = 0; m_phase = 0;
   endtask

   // One accepted clock edge of the timing loop in plain integer arithmetic.
   task automatic model_edge(input bit iv, input bit vv, input logic [15:0] ve);
      int  step;
      bit  run_next;
      run_next = m_run;
      m_strobe = 0;
      if (iv) begin
         if (!m_run) begin
            m_cnt++;
            if (m_cnt == WARMUP) run_next = 1;
         end else begin
            step = W_NOM + m_vhold;
            if (step < W_MIN) step = W_MIN;
            if (step > W_MAX) step = W_MAX;
            if (m_eta < step) begin
               m_strobe = 1;
               m_mu     = m_eta / 128;
               m_phase  = !m_phase;
               m_eta    = m_eta + 65536 - step;
               m_strb_cnt++;
            end else begin
               m_eta = m_eta - step;
            end
         end
      end
      if (vv) m_vhold = int'($signed(ve));
      m_run = run_next;
      exp_q.push_back({m_run, m_strobe, m_phase, 10'(m_mu)});
   endtask

   task automatic drive(input bit iv, input bit vv, input logic [15:0] ve);
      @(negedge clk);
      in_valid = iv; v_valid = vv; v_err = ve;
      @(posedge clk);
      model_edge(iv, vv, ve);
      #1;
      if (strobe) d_strb_cnt++;
   endtask

   task automatic do_reset(input bit pending);
      @(negedge clk);
      in_valid = pending; v_valid = 1'b0;
      #2 rst = 1'b1;
      #1;
      chk("rst_strobe", strobe, 0);
      chk("rst_mu", mu, 0);
      chk("rst_sym_phase", sym_phase, 0);
      chk("rst_running", running, 0);
      model_reset();
      exp_q.delete();
      @(negedge clk);
      in_valid = 1'b0;
      #2 rst = 1'b0;
   endtask

   always @(negedge clk) begin
      if (!rst && exp_q.size() > 0) begin
         cmp_exp = exp_q.pop_front();
         cmp_act = {running, strobe, sym_phase, mu};
         checks++;
         if (cmp_act !== cmp_exp) begin
            failures++;
            $display("FAIL cycle_cmp t=%0t: got run=%b stb=%b ph=%b mu=%0d expected run=%b stb=%b ph=%b mu=%0d",
                     $time, cmp_act[12], cmp_act[11], cmp_act[10], cmp_act[9:0],
                     cmp_exp[12], cmp_exp[11], cmp_exp[10], cmp_exp[9:0]);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      int first;
      int base;
      model_reset();
      m_strb_cnt = 0;

      // Warm-up then nominal 2 samples/symbol.
      do_reset(1'b0);
      for (int i = 0; i < 3; i++) drive(1'b1, 1'b0, 16'h0000);
      chk("warm_running_low", running, 0);
      drive(1'b1, 1'b0, 16'h0000);
      chk("warm_running_high", running, 1);
      chk("warm_model_running", m_run, 1);
      drive(1'b1, 1'b0, 16'h0000);
      chk("nom_s1_strobe", strobe, 0);
      drive(1'b1, 1'b0, 16'h0000);
      chk("nom_s2_strobe", strobe, 1);
      chk("nom_s2_mu", mu, 255);
      chk("nom_s2_phase", sym_phase, 1);
      chk("nom_model_mu", m_mu, 255);
      drive(1'b1, 1'b0, 16'h0000);
      chk("nom_s3_strobe", strobe, 0);
      drive(1'b1, 1'b0, 16'h0000);
      chk("nom_s4_strobe", strobe, 1);
      chk("nom_s4_phase", sym_phase, 0);
      for (int i = 0; i < 6; i++) drive(1'b1, 1'b0, 16'h0000);

      // Reset while an underflowing sample is on the input.
      drive(1'b1, 1'b0, 16'h0000);
      do_reset(1'b1);
      first = 0;
      for (int k = 1; k <= 10; k++) begin
         drive(1'b1, 1'b0, 16'h0000);
         if (strobe && first == 0) first = k;
      end
      chk("rst_mid_first_strobe", first, WARMUP + 2);

      // Gapped input: one sample every third cycle.
      base = d_strb_cnt;
      for (int i = 0; i < 30; i++) drive(i % 3 == 0, 1'b0, 16'h0000);
      chk("gap_strobe_count", d_strb_cnt - base, 5);
      chk("gap_mu_held", mu, 255);

      // v_valid coinciding with in_valid: new step applies from the next sample.
      do_reset(1'b0);
      for (int i = 0; i < WARMUP; i++) drive(1'b1, 1'b0, 16'h0000);
      drive(1'b1, 1'b1, 16'h7FFF);
      chk("coin_s1_strobe", strobe, 0);
      drive(1'b1, 1'b0, 16'h0000);
      chk("coin_s2_strobe", strobe, 1);
      chk("coin_s2_mu", mu, 255);
      drive(1'b1, 1'b0, 16'h0000);
      chk("coin_s3_strobe", strobe, 0);
      drive(1'b1, 1'b0, 16'h0000);
      chk("coin_s4_strobe", strobe, 1);
      chk("coin_s4_mu", mu, 127);
      chk("coin_s4_phase", sym_phase, 0);

      // Upper clamp: W = 0xA000 gives 62 strobes in 100 samples.
      do_reset(1'b0);
      drive(1'b0, 1'b1, 16'h7FFF);
      for (int i = 0; i < WARMUP; i++) drive(1'b1, 1'b0, 16'h0000);
      d_strb_cnt = 0; m_strb_cnt = 0;
      for (int i = 0; i < 100; i++) drive(1'b1, 1'b0, 16'h0000);
      chk("clamp_hi_dut_strobes", d_strb_cnt, 62);
      chk("clamp_hi_model_strobes", m_strb_cnt, 62);

      // Lower clamp: W = 0x6000 gives 37 strobes in 100 samples.
      do_reset(1'b0);
      drive(1'b0, 1'b1, 16'h8000);
      for (int i = 0; i < WARMUP; i++) drive(1'b1, 1'b0, 16'h0000);
      d_strb_cnt = 0; m_strb_cnt = 0;
      for (int i = 0; i < 100; i++) drive(1'b1, 1'b0, 16'h0000);
      chk("clamp_lo_dut_strobes", d_strb_cnt, 37);
      chk("clamp_lo_model_strobes", m_strb_cnt, 37);

      drive(1'b0, 1'b0, 16'h0000);
      drive(1'b0, 1'b0, 16'h0000);
      @(negedge clk);
      #1;
      chk("queue_drained", exp_q.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
